// File: rtl/ld_hazard_if.sv
// Bundle between the pipeline and the load hazard controller: stage status in, stall/bubble/forward controls and counters out.
interface ld_hazard_if #(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH     = 16
);
  logic                     ID_Valid;
  logic [RF_ADDR_WIDTH-1:0] ID_Rs1Addr;
  logic [RF_ADDR_WIDTH-1:0] ID_Rs2Addr;
  logic [RF_ADDR_WIDTH-1:0] ID_Rs3Addr;
  logic                     ID_Rs3EN;
  logic                     IDEX_Valid;
  logic                     IDEX_LdEN;
  logic [RF_ADDR_WIDTH-1:0] IDEX_RdAddr;
  logic [RF_ADDR_WIDTH-1:0] IDEX_Rs1Addr;
  logic [RF_ADDR_WIDTH-1:0] IDEX_Rs2Addr;
  logic [RF_ADDR_WIDTH-1:0] IDEX_Rs3Addr;
  logic                     Mem_LdEN;
  logic [RF_ADDR_WIDTH-1:0] EXMem_RdAddr;
  logic                     Dcache_DataVld;
  logic                     EX_Flush;

  logic                     Hazard_StallIF;
  logic                     Hazard_StallID;
  logic                     Hazard_BubbleEX;
  logic                     Hazard_StallEX;
  logic                     Hazard_StallMem;
  logic                     Hazard_Rs1FwdSel;
  logic                     Hazard_Rs2FwdSel;
  logic                     Hazard_Rs3FwdSel;
  logic [CNT_WIDTH-1:0]     Hazard_LuCnt;
  logic [CNT_WIDTH-1:0]     Hazard_MissCnt;
  logic                     Hazard_MissTimeout;

  modport master (
    output ID_Valid, ID_Rs1Addr, ID_Rs2Addr, ID_Rs3Addr, ID_Rs3EN,
           IDEX_Valid, IDEX_LdEN, IDEX_RdAddr, IDEX_Rs1Addr, IDEX_Rs2Addr, IDEX_Rs3Addr,
           Mem_LdEN, EXMem_RdAddr, Dcache_DataVld, EX_Flush,
    input  Hazard_StallIF, Hazard_StallID, Hazard_BubbleEX, Hazard_StallEX, Hazard_StallMem,
           Hazard_Rs1FwdSel, Hazard_Rs2FwdSel, Hazard_Rs3FwdSel,
           Hazard_LuCnt, Hazard_MissCnt, Hazard_MissTimeout
  );

  modport slave (
    input  ID_Valid, ID_Rs1Addr, ID_Rs2Addr, ID_Rs3Addr, ID_Rs3EN,
           IDEX_Valid, IDEX_LdEN, IDEX_RdAddr, IDEX_Rs1Addr, IDEX_Rs2Addr, IDEX_Rs3Addr,
           Mem_LdEN, EXMem_RdAddr, Dcache_DataVld, EX_Flush,
    output Hazard_StallIF, Hazard_StallID, Hazard_BubbleEX, Hazard_StallEX, Hazard_StallMem,
           Hazard_Rs1FwdSel, Hazard_Rs2FwdSel, Hazard_Rs3FwdSel,
           Hazard_LuCnt, Hazard_MissCnt, Hazard_MissTimeout
  );
endinterface

// File: rtl/ld_hazard_ctrl.sv
// Load hazard controller: one-cycle load-use bubble, full-pipeline freeze on Dcache miss,
// Dcache-return forward selects, saturating event counters and a sticky miss-timeout flag.
module ld_hazard_ctrl #(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH     = 16,
  parameter int MISS_TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  ld_hazard_if.slave hz
);

  typedef enum logic [0:0] {IDLE, MISS} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LIM = CNT_WIDTH'(MISS_TIMEOUT);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] wait_q, wait_d;
  logic [CNT_WIDTH-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
  logic                 timeout_q, timeout_d;

  logic miss;
  logic load_use;
  logic stall_miss;
  logic bubble;
  logic fwd_ok;

  // x0 is hardwired zero, so it never creates a dependency.
  function automatic logic addr_match(input logic [RF_ADDR_WIDTH-1:0] a,
                                      input logic [RF_ADDR_WIDTH-1:0] rd);
    return (a != '0) && (a == rd);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign miss = hz.Mem_LdEN & ~hz.Dcache_DataVld;

  assign load_use = hz.ID_Valid & hz.IDEX_Valid & hz.IDEX_LdEN &
                    (addr_match(hz.ID_Rs1Addr, hz.IDEX_RdAddr) |
                     addr_match(hz.ID_Rs2Addr, hz.IDEX_RdAddr) |
                     (hz.ID_Rs3EN & addr_match(hz.ID_Rs3Addr, hz.IDEX_RdAddr)));

  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    lu_cnt_d   = lu_cnt_q;
    miss_cnt_d = miss_cnt_q;
    timeout_d  = timeout_q;
    stall_miss = 1'b0;
    bubble     = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss) begin
          stall_miss = 1'b1;
          state_d    = MISS;
          wait_d     = CNT_ONE;
        end else if (load_use & ~hz.EX_Flush) begin
          bubble = 1'b1;
        end
      end
      MISS: begin
        // A dropped Mem_LdEN without data is a protocol error: fall back to IDLE quietly.
        if (miss) begin
          stall_miss = 1'b1;
          wait_d     = sat_inc(wait_q);
        end else begin
          state_d = IDLE;
          if (load_use & ~hz.EX_Flush) bubble = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (stall_miss) begin
      miss_cnt_d = sat_inc(miss_cnt_q);
      if (wait_d >= TIMEOUT_LIM) timeout_d = 1'b1;
    end
    if (bubble) lu_cnt_d = sat_inc(lu_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      lu_cnt_q   <= '0;
      miss_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      lu_cnt_q   <= lu_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Control outputs are gated by rst_n so an asserted reset releases the pipeline at once.
  assign hz.Hazard_StallIF  = rst_n & (stall_miss | bubble);
  assign hz.Hazard_StallID  = rst_n & (stall_miss | bubble);
  assign hz.Hazard_BubbleEX = rst_n & bubble;
  assign hz.Hazard_StallEX  = rst_n & stall_miss;
  assign hz.Hazard_StallMem = rst_n & stall_miss;

  assign fwd_ok = rst_n & hz.Mem_LdEN & hz.Dcache_DataVld & hz.IDEX_Valid &
                  ~((state_q == MISS) & ~hz.Dcache_DataVld);

  assign hz.Hazard_Rs1FwdSel = fwd_ok & addr_match(hz.IDEX_Rs1Addr, hz.EXMem_RdAddr);
  assign hz.Hazard_Rs2FwdSel = fwd_ok & addr_match(hz.IDEX_Rs2Addr, hz.EXMem_RdAddr);
  assign hz.Hazard_Rs3FwdSel = fwd_ok & addr_match(hz.IDEX_Rs3Addr, hz.EXMem_RdAddr);

  assign hz.Hazard_LuCnt       = lu_cnt_q;
  assign hz.Hazard_MissCnt     = miss_cnt_q;
  assign hz.Hazard_MissTimeout = timeout_q;

endmodule

// File: tb/tb_ld_hazard_ctrl.sv
// Bench for ld_hazard_ctrl: directed vector table, hand-written multi-cycle sequences, and random traffic against a reference model.
module tb_ld_hazard_ctrl;
  localparam int AW  = 5;
  localparam int CW  = 4;
  localparam int TMO = 3;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ld_hazard_if #(.RF_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus();

  ld_hazard_ctrl #(.RF_ADDR_WIDTH(AW), .CNT_WIDTH(CW), .MISS_TIMEOUT(TMO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       idv;
    logic [4:0] r1, r2, r3;
    logic       r3en;
    logic       exv, exld;
    logic [4:0] exrd, ex1, ex2, ex3;
    logic       mld;
    logic [4:0] mrd;
    logic       dv, fl;
    logic [3:0] e_stall;  // {IF, ID, EX, Mem}
    logic       e_bub;
    logic [2:0] e_fwd;    // {rs1, rs2, rs3}
    int         e_lu, e_mc;
    logic       e_to;
  } vec_t;

  vec_t tbl[$];

  // reference model state
  int m_lu, m_mc, m_run;
  bit m_to;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] stalls();
    return {bus.Hazard_StallIF, bus.Hazard_StallID, bus.Hazard_StallEX, bus.Hazard_StallMem};
  endfunction

  function automatic logic [2:0] fwds();
    return {bus.Hazard_Rs1FwdSel, bus.Hazard_Rs2FwdSel, bus.Hazard_Rs3FwdSel};
  endfunction

  task automatic drive(input vec_t v);
    bus.ID_Valid = v.idv;  bus.ID_Rs1Addr = v.r1; bus.ID_Rs2Addr = v.r2; bus.ID_Rs3Addr = v.r3;
    bus.ID_Rs3EN = v.r3en; bus.IDEX_Valid = v.exv; bus.IDEX_LdEN = v.exld; bus.IDEX_RdAddr = v.exrd;
    bus.IDEX_Rs1Addr = v.ex1; bus.IDEX_Rs2Addr = v.ex2; bus.IDEX_Rs3Addr = v.ex3;
    bus.Mem_LdEN = v.mld; bus.EXMem_RdAddr = v.mrd; bus.Dcache_DataVld = v.dv; bus.EX_Flush = v.fl;
  endtask

  function automatic vec_t quiet();
    vec_t v;
    v = '{0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0, 4'b0000,0,3'b000,0,0,0};
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    drive(quiet());
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_lu = 0; m_mc = 0; m_run = 0; m_to = 0;
  endtask

  // One cycle of miss-pending traffic (optionally with data), no other activity.
  task automatic miss_cycle(input logic dv);
    vec_t v;
    v = quiet();
    v.mld = 1'b1; v.dv = dv;
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
  endtask

  function automatic bit mt(input logic [4:0] a, input logic [4:0] rd);
    return (a != 0) && (a == rd);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    drive(quiet());
    rst_n = 1'b0;
    #12;
    // reset state: even with a miss presented, controls must read 0 under reset
    v = quiet(); v.mld = 1'b1; v.idv = 1; v.r1 = 3; v.exv = 1; v.exld = 1; v.exrd = 3;
    drive(v);
    #1;
    check("rst_stalls", int'(stalls()), 0);
    check("rst_bubble", int'(bus.Hazard_BubbleEX), 0);
    check("rst_lucnt", int'(bus.Hazard_LuCnt), 0);
    check("rst_misscnt", int'(bus.Hazard_MissCnt), 0);
    check("rst_timeout", int'(bus.Hazard_MissTimeout), 0);
    do_reset();

    // ---------------- directed table ----------------
    tbl.push_back('{0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0, 4'b0000,0,3'b000,0,0,0}); // idle
    tbl.push_back('{1,1,5,0,0, 1,1,5,0,0,0, 0,0,0,0, 4'b1100,1,3'b000,1,0,0}); // load-use on rs2=x5
    tbl.push_back('{1,2,3,0,0, 1,0,7,1,5,0, 1,5,1,0, 4'b0000,0,3'b010,1,0,0}); // rs2 forwarded from Dcache
    tbl.push_back('{1,0,0,0,0, 1,1,0,0,0,0, 0,0,0,0, 4'b0000,0,3'b000,1,0,0}); // x0 never hazards
    tbl.push_back('{1,1,2,9,1, 1,1,9,0,0,0, 0,0,0,0, 4'b1100,1,3'b000,2,0,0}); // rs3 load-use
    tbl.push_back('{1,1,2,9,0, 1,1,9,0,0,0, 0,0,0,0, 4'b0000,0,3'b000,2,0,0}); // rs3 not read
    tbl.push_back('{1,1,2,9,1, 1,1,9,0,0,0, 0,0,0,1, 4'b0000,0,3'b000,2,0,0}); // flush suppresses bubble
    tbl.push_back('{0,0,0,0,0, 1,0,3,4,4,4, 1,4,1,0, 4'b0000,0,3'b111,2,0,0}); // all three forwarded
    tbl.push_back('{0,0,0,0,0, 0,0,3,4,4,4, 1,4,1,0, 4'b0000,0,3'b000,2,0,0}); // EX invalid
    tbl.push_back('{0,0,0,0,0, 1,0,3,0,0,0, 1,0,1,0, 4'b0000,0,3'b000,2,0,0}); // x0 not forwarded
    tbl.push_back('{1,6,0,0,0, 1,1,6,6,0,0, 1,6,0,1, 4'b1111,0,3'b000,2,1,0}); // miss + load-use + flush
    tbl.push_back('{1,6,0,0,0, 1,1,6,6,0,0, 1,6,0,0, 4'b1111,0,3'b000,2,2,0}); // miss cycle 2
    tbl.push_back('{1,6,0,0,0, 1,1,6,6,0,0, 1,6,0,0, 4'b1111,0,3'b000,2,3,1}); // miss cycle 3: timeout
    tbl.push_back('{1,6,0,0,0, 1,1,6,6,0,0, 1,6,0,0, 4'b1111,0,3'b000,2,4,1}); // miss cycle 4
    tbl.push_back('{1,6,0,0,0, 1,1,6,6,0,0, 1,6,1,1, 4'b0000,0,3'b100,2,4,1}); // data returns, flush
    tbl.push_back('{1,6,0,0,0, 1,1,6,0,0,0, 0,0,0,0, 4'b1100,1,3'b000,3,4,1}); // load-use re-evaluated
    tbl.push_back('{0,0,0,0,0, 0,0,0,0,0,0, 1,2,0,0, 4'b1111,0,3'b000,3,5,1}); // new miss
    tbl.push_back('{0,0,0,0,0, 0,0,0,0,0,0, 0,2,0,0, 4'b0000,0,3'b000,3,5,1}); // Mem_LdEN dropped
    tbl.push_back('{0,0,0,0,0, 0,0,0,0,0,0, 1,2,0,0, 4'b1111,0,3'b000,3,6,1}); // miss again
    tbl.push_back('{0,0,0,0,0, 0,0,0,0,0,0, 1,2,1,0, 4'b0000,0,3'b000,3,6,1}); // data returns

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check($sformatf("t%0d_stalls", i), int'(stalls()), int'(tbl[i].e_stall));
      check($sformatf("t%0d_bubble", i), int'(bus.Hazard_BubbleEX), int'(tbl[i].e_bub));
      check($sformatf("t%0d_fwd", i), int'(fwds()), int'(tbl[i].e_fwd));
      @(posedge clk);
      #1;
      check($sformatf("t%0d_lucnt", i), int'(bus.Hazard_LuCnt), tbl[i].e_lu);
      check($sformatf("t%0d_misscnt", i), int'(bus.Hazard_MissCnt), tbl[i].e_mc);
      check($sformatf("t%0d_timeout", i), int'(bus.Hazard_MissTimeout), int'(tbl[i].e_to));
    end

    // ---------------- 6-cycle miss with timeout ----------------
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      miss_cycle(1'b0);
      check($sformatf("tmo_c%0d", k), int'(bus.Hazard_MissTimeout), (k >= TMO) ? 1 : 0);
    end
    miss_cycle(1'b1);
    check("tmo_after_return", int'(bus.Hazard_MissTimeout), 1);
    check("tmo_misscnt", int'(bus.Hazard_MissCnt), 6);
    @(negedge clk);
    drive(quiet());
    @(posedge clk);
    #1;
    check("tmo_sticky", int'(bus.Hazard_MissTimeout), 1);

    // ---------------- reset in the 2nd MISS cycle ----------------
    do_reset();
    miss_cycle(1'b0);
    @(negedge clk);
    v = quiet(); v.mld = 1'b1;
    drive(v);
    #1;
    check("rmid_stall_before", int'(stalls()), 4'b1111);
    rst_n = 1'b0;
    #1;
    check("rmid_stalls", int'(stalls()), 0);
    check("rmid_misscnt", int'(bus.Hazard_MissCnt), 0);
    check("rmid_timeout", int'(bus.Hazard_MissTimeout), 0);
    @(negedge clk);
    drive(quiet());
    rst_n = 1'b1;
    #1;
    check("rmid_rel_stalls", int'(stalls()), 0);
    @(posedge clk);
    #1;
    check("rmid_rel_misscnt", int'(bus.Hazard_MissCnt), 0);
    check("rmid_rel_lucnt", int'(bus.Hazard_LuCnt), 0);

    // ---------------- counter saturation ----------------
    for (int k = 0; k < SAT + 5; k++) begin
      @(negedge clk);
      v = quiet(); v.idv = 1; v.r2 = 7; v.exv = 1; v.exld = 1; v.exrd = 7;
      drive(v);
      @(posedge clk);
    end
    #1;
    check("lucnt_sat", int'(bus.Hazard_LuCnt), SAT);
    for (int k = 0; k < SAT + 5; k++) miss_cycle(1'b0);
    check("misscnt_sat", int'(bus.Hazard_MissCnt), SAT);
    miss_cycle(1'b1);

    // ---------------- random traffic vs model ----------------
    do_reset();
    for (int n = 0; n < 500; n++) begin
      bit miss, lu, bub;
      logic [2:0] efwd;
      @(negedge clk);
      v = quiet();
      v.idv  = 1'($urandom_range(0, 1));
      v.r1   = 5'($urandom_range(0, 3));
      v.r2   = 5'($urandom_range(0, 3));
      v.r3   = 5'($urandom_range(0, 3));
      v.r3en = 1'($urandom_range(0, 1));
      v.exv  = 1'($urandom_range(0, 1));
      v.exld = 1'($urandom_range(0, 1));
      v.exrd = 5'($urandom_range(0, 3));
      v.ex1  = 5'($urandom_range(0, 3));
      v.ex2  = 5'($urandom_range(0, 3));
      v.ex3  = 5'($urandom_range(0, 3));
      v.mld  = 1'($urandom_range(0, 1));
      v.mrd  = 5'($urandom_range(0, 3));
      v.dv   = ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0;
      v.fl   = ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0;
      drive(v);
      #1;
      miss = v.mld && !v.dv;
      lu   = v.idv && v.exv && v.exld &&
             (mt(v.r1, v.exrd) || mt(v.r2, v.exrd) || (v.r3en && mt(v.r3, v.exrd)));
      bub  = !miss && lu && !v.fl;
      efwd = {v.mld && v.dv && v.exv && mt(v.ex1, v.mrd),
              v.mld && v.dv && v.exv && mt(v.ex2, v.mrd),
              v.mld && v.dv && v.exv && mt(v.ex3, v.mrd)};
      check($sformatf("r%0d_stalls", n), int'(stalls()), int'({miss || bub, miss || bub, miss, miss}));
      check($sformatf("r%0d_bubble", n), int'(bus.Hazard_BubbleEX), int'(bub));
      check($sformatf("r%0d_fwd", n), int'(fwds()), int'(efwd));
      @(posedge clk);
      #1;
      if (miss) begin
        m_run++;
        if (m_mc < SAT) m_mc++;
        if (m_run >= TMO) m_to = 1;
      end else begin
        m_run = 0;
      end
      if (bub && m_lu < SAT) m_lu++;
      check($sformatf("r%0d_lucnt", n), int'(bus.Hazard_LuCnt), m_lu);
      check($sformatf("r%0d_misscnt", n), int'(bus.Hazard_MissCnt), m_mc);
      check($sformatf("r%0d_timeout", n), int'(bus.Hazard_MissTimeout), int'(m_to));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
